// File: rtl/psum_accumulator.sv
// Registered partial-sum accumulator: sums TERMS unsigned adder results per group, saturating,
// and hands each group result downstream over a valid/ready handshake.
module psum_accumulator #(
    parameter int unsigned IN_W  = 5,
    parameter int unsigned ACC_W = 12,
    parameter int unsigned TERMS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf
);

    localparam int unsigned CNT_W = (TERMS > 1) ? $clog2(TERMS) : 1;
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TERMS - 1);

    typedef enum logic [0:0] {StAcc, StHold} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   out_data_q, out_data_d;
    logic               out_ovf_q, out_ovf_d;
    logic               out_valid_q, out_valid_d;

    logic               accept;
    logic [ACC_W-1:0]   in_zext;
    logic [ACC_W:0]     sum;
    logic [ACC_W-1:0]   acc_next;
    logic               ovf_next;

    assign in_ready  = (state_q == StAcc);
    assign accept    = in_valid & in_ready;
    assign in_zext   = ACC_W'(in_data);
    assign sum       = {1'b0, acc_q} + {1'b0, in_zext};

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

    // Value the accumulator takes if this cycle's input is accepted.
    always_comb begin
        acc_next = in_zext;
        ovf_next = 1'b0;
        if (cnt_q != '0) begin
            if (sum[ACC_W] || ovf_q) begin
                acc_next = '1;
                ovf_next = 1'b1;
            end else begin
                acc_next = sum[ACC_W-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            StAcc: begin
                // clear wins over a same-cycle accept; the input is dropped.
                if (clear) begin
                    cnt_d = '0;
                    ovf_d = 1'b0;
                end else if (accept) begin
                    acc_d = acc_next;
                    ovf_d = ovf_next;
                    if (cnt_q == CntLast) begin
                        out_data_d  = acc_next;
                        out_ovf_d   = ovf_next;
                        out_valid_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = StHold;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            StHold: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StAcc;
                end
            end
            default: state_d = StAcc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StAcc;
            cnt_q       <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator: three instances (TERMS=4, TERMS=16, TERMS=1) driven
// step by step with hand-computed expected results.
module tb_psum_accumulator;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: TERMS=4, ACC_W=8
    logic       a_clear, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_ovf;
    logic [4:0] a_in_data;
    logic [7:0] a_out_data;
    // Instance B: TERMS=16, ACC_W=8
    logic       b_clear, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ovf;
    logic [4:0] b_in_data;
    logic [7:0] b_out_data;
    // Instance C: TERMS=1, ACC_W=12
    logic        c_clear, c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_ovf;
    logic [4:0]  c_in_data;
    logic [11:0] c_out_data;

    int checks = 0;
    int errors = 0;

    psum_accumulator #(.IN_W(5), .ACC_W(8), .TERMS(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(a_clear), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .in_data(a_in_data), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_data(a_out_data), .out_ovf(a_out_ovf)
    );

    psum_accumulator #(.IN_W(5), .ACC_W(8), .TERMS(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(b_clear), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .in_data(b_in_data), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data), .out_ovf(b_out_ovf)
    );

    psum_accumulator #(.IN_W(5), .ACC_W(12), .TERMS(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .clear(c_clear), .in_valid(c_in_valid),
        .in_ready(c_in_ready), .in_data(c_in_data), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .out_data(c_out_data), .out_ovf(c_out_ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_push(input logic [4:0] d);
        a_in_valid = 1'b1;
        a_in_data  = d;
        tick();
    endtask

    initial begin
        a_clear = 0; a_in_valid = 0; a_in_data = 0; a_out_ready = 1;
        b_clear = 0; b_in_valid = 0; b_in_data = 0; b_out_ready = 1;
        c_clear = 0; c_in_valid = 0; c_in_data = 0; c_out_ready = 1;
        #12;
        check("reset_out_valid", a_out_valid, 0);
        check("reset_out_data", a_out_data, 0);
        check("reset_out_ovf", a_out_ovf, 0);
        rst_n = 1'b1;
        tick();
        check("reset_in_ready", a_in_ready, 1);

        // T1: 1,2,3,4 back-to-back, out_ready high
        a_push(1); a_push(2); a_push(3);
        check("t1_not_yet_valid", a_out_valid, 0);
        a_push(4);
        a_in_valid = 0;
        check("t1_out_valid", a_out_valid, 1);
        check("t1_out_data", a_out_data, 10);
        check("t1_out_ovf", a_out_ovf, 0);
        check("t1_in_ready_hold", a_in_ready, 0);
        tick();
        check("t1_valid_one_cycle", a_out_valid, 0);
        check("t1_in_ready_back", a_in_ready, 1);

        // T3: backpressure for 6 cycles
        a_out_ready = 0;
        a_push(5); a_push(6); a_push(7); a_push(8);
        a_in_valid = 0;
        for (int i = 0; i < 6; i++) begin
            check("t3_hold_valid", a_out_valid, 1);
            check("t3_hold_data", a_out_data, 26);
            check("t3_hold_in_ready", a_in_ready, 0);
            tick();
        end
        a_out_ready = 1;
        tick();
        check("t3_released_valid", a_out_valid, 0);
        check("t3_released_in_ready", a_in_ready, 1);
        check("t3_data_kept", a_out_data, 26);

        // T4: bubbles 1,0,0,1,0,1,1 with data 3,x,x,3,x,3,3
        a_push(3);
        a_in_valid = 0; a_in_data = 7; tick();
        a_in_data = 9; tick();
        a_push(3);
        a_in_valid = 0; a_in_data = 31; tick();
        a_push(3);
        check("t4_no_early_result", a_out_valid, 0);
        a_push(3);
        a_in_valid = 0;
        check("t4_out_valid", a_out_valid, 1);
        check("t4_out_data", a_out_data, 12);
        tick();
        tick();
        check("t4_single_result", a_out_valid, 0);

        // T5: clear drops partial group; clear in HOLD keeps result
        a_push(9); a_push(9);
        a_clear = 1; a_in_valid = 1; a_in_data = 9; tick();
        a_clear = 0;
        a_out_ready = 0;
        a_push(1); a_push(1); a_push(1); a_push(1);
        a_in_valid = 0;
        check("t5_out_valid", a_out_valid, 1);
        check("t5_out_data", a_out_data, 4);
        a_clear = 1; tick(); a_clear = 0;
        check("t5_clear_hold_valid", a_out_valid, 1);
        check("t5_clear_hold_data", a_out_data, 4);
        a_out_ready = 1; tick();
        check("t5_delivered", a_out_valid, 0);

        // T6a: async reset after 3 of 4 inputs
        a_push(2); a_push(2); a_push(2);
        a_in_valid = 0;
        #2 rst_n = 0;
        #1;
        check("t6_mid_out_valid", a_out_valid, 0);
        check("t6_mid_out_data", a_out_data, 0);
        @(negedge clk); rst_n = 1; #1;
        tick();
        a_push(1); a_push(2); a_push(3); a_push(4);
        a_in_valid = 0;
        check("t6_fresh_group", a_out_data, 10);
        tick();
        // T6b: async reset during HOLD
        a_out_ready = 0;
        a_push(5); a_push(5); a_push(5); a_push(5);
        a_in_valid = 0;
        check("t6_hold_valid", a_out_valid, 1);
        #2 rst_n = 0;
        #1;
        check("t6_hold_rst_valid", a_out_valid, 0);
        check("t6_hold_rst_data", a_out_data, 0);
        check("t6_hold_rst_in_ready", a_in_ready, 1);
        @(negedge clk); rst_n = 1; #1;
        tick();
        a_out_ready = 1;
        a_push(5); a_push(5); a_push(5); a_push(5);
        a_in_valid = 0;
        check("t6_after_hold_group", a_out_data, 20);
        check("t6_after_hold_ovf", a_out_ovf, 0);

        // T2: TERMS=16 saturation, then input held valid through the idle cycle
        b_in_valid = 1; b_in_data = 31;
        for (int i = 0; i < 15; i++) tick();
        check("t2_not_yet_valid", b_out_valid, 0);
        tick();
        check("t2_sat_valid", b_out_valid, 1);
        check("t2_sat_data", b_out_data, 255);
        check("t2_sat_ovf", b_out_ovf, 1);
        b_in_data = 4;
        tick();
        check("t2_idle_cycle", b_out_valid, 0);
        for (int i = 0; i < 15; i++) tick();
        check("t2_hold_input_ignored", b_out_valid, 0);
        tick();
        b_in_valid = 0;
        check("t2_second_valid", b_out_valid, 1);
        check("t2_second_data", b_out_data, 64);
        check("t2_second_ovf", b_out_ovf, 0);

        // TERMS=1: each accepted input is a result
        c_in_valid = 1; c_in_data = 17; tick();
        c_in_valid = 0;
        check("terms1_data", c_out_data, 17);
        check("terms1_valid", c_out_valid, 1);
        tick();
        check("terms1_drained", c_out_valid, 0);
        c_in_valid = 1; c_in_data = 3; tick();
        c_in_valid = 0;
        check("terms1_second", c_out_data, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
